// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port.
// Assembles big-endian words and holds the CPU until the program is in.
module imem_loader #(
    parameter int DEPTH = 100,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      maddr_q, maddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ready_q, ready_d;
    logic             we_q, we_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic             hs;
    logic [CNT_W-1:0] word_n;

    // Zero-length and oversize programs are refused before anything is written.
    assign start_ok = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
    assign hs       = byte_valid && ready_q;
    assign word_n   = word_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        num_d      = num_q;
        addr_d     = addr_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        we_d       = 1'b0;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        err_d      = 1'b0;
                        num_d      = num_words;
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        ready_d    = 1'b1;
                        done_d     = 1'b0;
                        hold_d     = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wdata_d    = {wdata_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        ready_d = 1'b0;
                        we_d    = 1'b1;
                        maddr_d = addr_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d     = addr_q + 32'd4;
                word_cnt_d = word_n;
                if (word_n == num_q) begin
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            num_q      <= '0;
            addr_q     <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            num_q      <= num_d;
            addr_q     <= addr_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign byte_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule
